// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with NZCV flags.
// The carry chain is cut into STAGES equal slices, one register boundary per slice, with valid/ready flow control.
module pipelined_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             negative,
  output logic             zero,
  output logic             carryOut,
  output logic             overflow
);

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  function automatic logic [SW:0] add_slice(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic          ci);
    return {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, ci};
  endfunction

  function automatic logic ovf_flag(input logic a_msb,
                                    input logic b_msb,
                                    input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic              stall;
  logic              adv;
  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] vin;

  logic [WIDTH-1:0]  a_p [STAGES];
  logic [WIDTH-1:0]  b_p [STAGES];
  logic [WIDTH-1:0]  s_p [STAGES];
  logic              c_p [STAGES];
  logic              z_p [STAGES];

  logic [WIDTH-1:0]  a_n [STAGES];
  logic [WIDTH-1:0]  b_n [STAGES];
  logic [WIDTH-1:0]  s_n [STAGES];
  logic              c_n [STAGES];
  logic              z_n [STAGES];

  assign out_valid = vld_p[L];
  assign stall     = out_valid & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;

  // Stage k adds slice k of the operands that travelled with the operation,
  // using the carry registered by stage k-1; zero is accumulated slice by slice.
  always_comb begin : slice_chain
    logic [SW:0]      sl;
    logic [WIDTH-1:0] bx;
    vin     = '0;
    bx      = B ^ {WIDTH{sub}};
    sl      = add_slice(A[SW-1:0], bx[SW-1:0], sub);
    a_n[0]  = A;
    b_n[0]  = bx;
    s_n[0]  = '0;
    s_n[0][SW-1:0] = sl[SW-1:0];
    c_n[0]  = sl[SW];
    z_n[0]  = ~|sl[SW-1:0];
    vin[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      sl     = add_slice(a_p[k-1][k*SW +: SW], b_p[k-1][k*SW +: SW], c_p[k-1]);
      a_n[k] = a_p[k-1];
      b_n[k] = b_p[k-1];
      s_n[k] = s_p[k-1];
      s_n[k][k*SW +: SW] = sl[SW-1:0];
      c_n[k] = sl[SW];
      z_n[k] = z_p[k-1] & ~|sl[SW-1:0];
      vin[k] = vld_p[k-1];
    end
  end

  // Stage boundary: valid bits (reset and flush act here only)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p <= vin;
    end
  end

  // Stage boundary: operand skew, partial sum, carry and zero registers
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_p[k] <= a_n[k];
        b_p[k] <= b_n[k];
        s_p[k] <= s_n[k];
        c_p[k] <= c_n[k];
        z_p[k] <= z_n[k];
      end
    end
  end

  // Outputs read zero whenever no result is presented, so reset clears them at once.
  assign sum      = out_valid ? s_p[L] : '0;
  assign negative = out_valid & s_p[L][WIDTH-1];
  assign zero     = out_valid & z_p[L];
  assign carryOut = out_valid & c_p[L];
  assign overflow = out_valid & ovf_flag(a_p[L][WIDTH-1], b_p[L][WIDTH-1], s_p[L][WIDTH-1]);

  property p_stall_hold;
    @(posedge clk) disable iff (reset)
      (stall && !flush) |=> (out_valid && $stable(sum));
  endproperty
  assert property (p_stall_hold);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub at 64/4, 64/1 and 8/8.
// Covers flags, latency, stall, flush and asynchronous reset.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        flush4, in_valid4, sub4, out_ready4;
  logic [63:0] a4, b4;
  logic        in_ready4, out_valid4, n4, z4, c4, v4;
  logic [63:0] sum4;

  logic        flush1, in_valid1, sub1, out_ready1;
  logic [63:0] a1, b1;
  logic        in_ready1, out_valid1, n1, z1, c1, v1;
  logic [63:0] sum1;

  logic        flush8, in_valid8, sub8, out_ready8;
  logic [7:0]  a8, b8;
  logic        in_ready8, out_valid8, n8, z8, c8, v8;
  logic [7:0]  sum8;

  pipelined_addsub #(.WIDTH(64), .STAGES(4)) u_dut4 (
    .clk(clk), .reset(reset), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
    .sub(sub4), .A(a4), .B(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .negative(n4), .zero(z4), .carryOut(c4), .overflow(v4));

  pipelined_addsub #(.WIDTH(64), .STAGES(1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .sub(sub1), .A(a1), .B(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .negative(n1), .zero(z1), .carryOut(c1), .overflow(v1));

  pipelined_addsub #(.WIDTH(8), .STAGES(8)) u_dut8 (
    .clk(clk), .reset(reset), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .sub(sub8), .A(a8), .B(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .negative(n8), .zero(z8), .carryOut(c8), .overflow(v8));

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic [63:0] sum;
    logic [3:0]  nzcv;
  } vec_t;

  vec_t v64 [6];
  vec_t v8t [6];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input int i);
    a4 = v64[i].a; b4 = v64[i].b; sub4 = v64[i].s; in_valid4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    step();
    step();
    chk($sformatf("lat4[%0d]", i), 64'(out_valid4), 0);
    step();
    chk($sformatf("vld4[%0d]", i), 64'(out_valid4), 1);
    chk($sformatf("sum4[%0d]", i), sum4, v64[i].sum);
    chk($sformatf("nzcv4[%0d]", i), 64'({n4, z4, c4, v4}), 64'(v64[i].nzcv));
    step();
  endtask

  task automatic run1(input int i);
    a1 = v64[i].a; b1 = v64[i].b; sub1 = v64[i].s; in_valid1 = 1'b1;
    chk($sformatf("pre1[%0d]", i), 64'(out_valid1), 0);
    step();
    in_valid1 = 1'b0;
    chk($sformatf("vld1[%0d]", i), 64'(out_valid1), 1);
    chk($sformatf("sum1[%0d]", i), sum1, v64[i].sum);
    chk($sformatf("nzcv1[%0d]", i), 64'({n1, z1, c1, v1}), 64'(v64[i].nzcv));
    step();
  endtask

  task automatic run8(input int i);
    a8 = v8t[i].a[7:0]; b8 = v8t[i].b[7:0]; sub8 = v8t[i].s; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    repeat (6) step();
    chk($sformatf("lat8[%0d]", i), 64'(out_valid8), 0);
    step();
    chk($sformatf("vld8[%0d]", i), 64'(out_valid8), 1);
    chk($sformatf("sum8[%0d]", i), 64'(sum8), v8t[i].sum);
    chk($sformatf("nzcv8[%0d]", i), 64'({n8, z8, c8, v8}), 64'(v8t[i].nzcv));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int issued;
    int rcv;

    v64[0] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
    v64[1] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 4'b0000};
    v64[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0,                   4'b0110};
    v64[3] = '{64'h5,                   64'h5, 1'b1, 64'h0,                   4'b0110};
    v64[4] = '{64'h3,                   64'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
    v64[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};

    v8t[0] = '{64'h7F, 64'h01, 1'b0, 64'h80, 4'b1001};
    v8t[1] = '{64'h0F, 64'h01, 1'b0, 64'h10, 4'b0000};
    v8t[2] = '{64'hFF, 64'h01, 1'b0, 64'h00, 4'b0110};
    v8t[3] = '{64'h05, 64'h05, 1'b1, 64'h00, 4'b0110};
    v8t[4] = '{64'h03, 64'h05, 1'b1, 64'hFE, 4'b1000};
    v8t[5] = '{64'h80, 64'h01, 1'b1, 64'h7F, 4'b0011};

    reset = 1'b1;
    flush4 = 1'b0; in_valid4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0;
    flush1 = 1'b0; in_valid1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0;
    flush8 = 1'b0; in_valid8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    step();

    chk("rst_vld", 64'(out_valid4), 0);
    chk("rst_sum", sum4, 0);
    chk("rst_flags", 64'({n4, z4, c4, v4}), 0);
    chk("rst_rdy", 64'(in_ready4), 1);
    chk("rst_vld1", 64'(out_valid1), 0);
    chk("rst_vld8", 64'(out_valid8), 0);

    for (int i = 0; i < 6; i++) run4(i);

    // Eight back-to-back ops, consumer stalls for three cycles mid-stream.
    issued = 0;
    rcv    = 0;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      out_ready4 = !(cyc >= 5 && cyc <= 7);
      in_valid4  = (issued < 8);
      a4 = 64'hFFFF; b4 = 64'(issued + 1); sub4 = 1'b0;
      #1;
      if (!out_ready4) begin
        chk("stall_rdy", 64'(in_ready4), 0);
        chk("stall_hold", sum4, 64'h10001);
      end
      if (out_valid4 && out_ready4) begin
        chk($sformatf("stall_res%0d", rcv), sum4, 64'h10000 + 64'(rcv));
        rcv++;
      end else if (out_ready4 && rcv > 0) begin
        chk("stall_gap", 64'(out_valid4), 1);
      end
      if (in_valid4 && in_ready4) issued++;
      step();
    end
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    chk("stall_count", 64'(rcv), 8);
    step();

    // Flush with three ops in flight and a fourth presented in the same cycle.
    for (int j = 0; j < 3; j++) begin
      in_valid4 = 1'b1; a4 = 64'(j); b4 = 64'h1; sub4 = 1'b0;
      step();
    end
    in_valid4 = 1'b1; a4 = 64'h55; flush4 = 1'b1;
    step();
    flush4 = 1'b0;
    in_valid4 = 1'b1; a4 = 64'h1234; b4 = 64'h1; sub4 = 1'b1;
    chk("flush_c4", 64'(out_valid4), 0);
    step();
    in_valid4 = 1'b0;
    for (int j = 5; j < 8; j++) begin
      chk($sformatf("flush_c%0d", j), 64'(out_valid4), 0);
      step();
    end
    chk("flush_new_vld", 64'(out_valid4), 1);
    chk("flush_new_sum", sum4, 64'h1233);
    step();

    // Asynchronous reset with a full pipeline.
    for (int j = 0; j < 4; j++) begin
      in_valid4 = 1'b1; a4 = 64'hFFFF_FFFF_FFFF_FFFF; b4 = 64'h1; sub4 = 1'b0;
      step();
    end
    in_valid4 = 1'b0;
    chk("prerst_vld", 64'(out_valid4), 1);
    chk("prerst_flags", 64'({n4, z4, c4, v4}), 64'h6);
    #2 reset = 1'b1;
    #1;
    chk("arst_vld", 64'(out_valid4), 0);
    chk("arst_sum", sum4, 0);
    chk("arst_flags", 64'({n4, z4, c4, v4}), 0);
    #3 reset = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      chk($sformatf("postrst_vld%0d", j), 64'(out_valid4), 0);
    end

    for (int i = 0; i < 6; i++) run1(i);
    for (int i = 0; i < 6; i++) run8(i);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
